// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and ALU issue bundle for the ALU reservation station.
// The station takes the slave side; the dispatcher/CDB/ALU environment takes the master side.
interface alu_reservation_station_if #(
    parameter int CSU_SIZE_BITS = 4
) ();
    logic                     dispatch_valid;
    logic [CSU_SIZE_BITS-1:0] dispatch_ins_id;
    logic [6:0]               dispatch_opcode;
    logic [2:0]               dispatch_funct3;
    logic [6:0]               dispatch_funct7;
    logic [31:0]              dispatch_imm;
    logic [5:0]               dispatch_shamt;
    logic [31:0]              dispatch_pc;
    logic                     dispatch_is_compressed;
    logic                     dispatch_rs1_rdy;
    logic [31:0]              dispatch_rs1_val;
    logic [CSU_SIZE_BITS-1:0] dispatch_rs1_tag;
    logic                     dispatch_rs2_rdy;
    logic [31:0]              dispatch_rs2_val;
    logic [CSU_SIZE_BITS-1:0] dispatch_rs2_tag;
    logic                     rs_full;

    logic                     cdb_valid;
    logic [CSU_SIZE_BITS-1:0] cdb_ins_id;
    logic [31:0]              cdb_val;

    logic                     have_ins;
    logic [CSU_SIZE_BITS-1:0] ins_id;
    logic [31:0]              rs1_val;
    logic [31:0]              rs2_val;
    logic [31:0]              imm_val;
    logic [5:0]               shamt_val;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [31:0]              request_PC;
    logic                     is_compressed_ins;

    modport master (
        output dispatch_valid, dispatch_ins_id, dispatch_opcode, dispatch_funct3,
               dispatch_funct7, dispatch_imm, dispatch_shamt, dispatch_pc,
               dispatch_is_compressed, dispatch_rs1_rdy, dispatch_rs1_val,
               dispatch_rs1_tag, dispatch_rs2_rdy, dispatch_rs2_val, dispatch_rs2_tag,
               cdb_valid, cdb_ins_id, cdb_val,
        input  rs_full, have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val,
               opcode, funct3, funct7, request_PC, is_compressed_ins
    );

    modport slave (
        input  dispatch_valid, dispatch_ins_id, dispatch_opcode, dispatch_funct3,
               dispatch_funct7, dispatch_imm, dispatch_shamt, dispatch_pc,
               dispatch_is_compressed, dispatch_rs1_rdy, dispatch_rs1_val,
               dispatch_rs1_tag, dispatch_rs2_rdy, dispatch_rs2_val, dispatch_rs2_tag,
               cdb_valid, cdb_ins_id, cdb_val,
        output rs_full, have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val,
               opcode, funct3, funct7, request_PC, is_compressed_ins
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched instructions, snoops the CDB for missing
// operands and issues the lowest-index ready entry to the ALU through output registers.
module alu_reservation_station #(
    parameter int RS_SIZE_BITS  = 2,
    parameter int RS_SIZE       = 4,
    parameter int CSU_SIZE_BITS = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush_pipline,
    alu_reservation_station_if.slave      rs_if
);

    logic [RS_SIZE-1:0]       r_busy;
    logic [CSU_SIZE_BITS-1:0] r_id      [RS_SIZE];
    logic [6:0]               r_opcode  [RS_SIZE];
    logic [2:0]               r_funct3  [RS_SIZE];
    logic [6:0]               r_funct7  [RS_SIZE];
    logic [31:0]              r_imm     [RS_SIZE];
    logic [5:0]               r_shamt   [RS_SIZE];
    logic [31:0]              r_pc      [RS_SIZE];
    logic [RS_SIZE-1:0]       r_cmp;
    logic [RS_SIZE-1:0]       r_rs1_rdy;
    logic [31:0]              r_rs1_val [RS_SIZE];
    logic [CSU_SIZE_BITS-1:0] r_rs1_tag [RS_SIZE];
    logic [RS_SIZE-1:0]       r_rs2_rdy;
    logic [31:0]              r_rs2_val [RS_SIZE];
    logic [CSU_SIZE_BITS-1:0] r_rs2_tag [RS_SIZE];

    logic                     r_vld_p1;
    logic [CSU_SIZE_BITS-1:0] r_id_p1;
    logic [31:0]              r_rs1_p1;
    logic [31:0]              r_rs2_p1;
    logic [31:0]              r_imm_p1;
    logic [5:0]               r_shamt_p1;
    logic [6:0]               r_opcode_p1;
    logic [2:0]               r_funct3_p1;
    logic [6:0]               r_funct7_p1;
    logic [31:0]              r_pc_p1;
    logic                     r_cmp_p1;

    logic                     w_full;
    logic                     w_disp;
    logic [RS_SIZE_BITS-1:0]  w_free_idx;
    logic                     w_iss_any;
    logic [RS_SIZE_BITS-1:0]  w_iss_idx;
    logic [RS_SIZE-1:0]       w_wake1;
    logic [RS_SIZE-1:0]       w_wake2;
    logic                     w_d1_hit;
    logic                     w_d2_hit;

    assign w_full   = &r_busy;
    assign w_disp   = rs_if.dispatch_valid && !w_full;
    assign w_d1_hit = !rs_if.dispatch_rs1_rdy && rs_if.cdb_valid &&
                      (rs_if.dispatch_rs1_tag == rs_if.cdb_ins_id);
    assign w_d2_hit = !rs_if.dispatch_rs2_rdy && rs_if.cdb_valid &&
                      (rs_if.dispatch_rs2_tag == rs_if.cdb_ins_id);

    // Descending scans so the lowest matching index is the one that sticks.
    always_comb begin
        w_free_idx = '0;
        w_iss_idx  = '0;
        w_iss_any  = 1'b0;
        w_wake1    = '0;
        w_wake2    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = RS_SIZE_BITS'(i);
            end
            if (r_busy[i] && r_rs1_rdy[i] && r_rs2_rdy[i]) begin
                w_iss_idx = RS_SIZE_BITS'(i);
                w_iss_any = 1'b1;
            end
            w_wake1[i] = r_busy[i] && !r_rs1_rdy[i] && rs_if.cdb_valid &&
                         (r_rs1_tag[i] == rs_if.cdb_ins_id);
            w_wake2[i] = r_busy[i] && !r_rs2_rdy[i] && rs_if.cdb_valid &&
                         (r_rs2_tag[i] == rs_if.cdb_ins_id);
        end
    end

    // Entry storage, wake-up and the single issue register stage (p1).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy      <= '0;
            r_vld_p1    <= 1'b0;
            r_id_p1     <= '0;
            r_rs1_p1    <= '0;
            r_rs2_p1    <= '0;
            r_imm_p1    <= '0;
            r_shamt_p1  <= '0;
            r_opcode_p1 <= '0;
            r_funct3_p1 <= '0;
            r_funct7_p1 <= '0;
            r_pc_p1     <= '0;
            r_cmp_p1    <= 1'b0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                r_busy   <= '0;
                r_vld_p1 <= 1'b0;
            end else begin
                r_vld_p1 <= w_iss_any;
                if (w_iss_any) begin
                    r_id_p1              <= r_id[w_iss_idx];
                    r_rs1_p1             <= r_rs1_val[w_iss_idx];
                    r_rs2_p1             <= r_rs2_val[w_iss_idx];
                    r_imm_p1             <= r_imm[w_iss_idx];
                    r_shamt_p1           <= r_shamt[w_iss_idx];
                    r_opcode_p1          <= r_opcode[w_iss_idx];
                    r_funct3_p1          <= r_funct3[w_iss_idx];
                    r_funct7_p1          <= r_funct7[w_iss_idx];
                    r_pc_p1              <= r_pc[w_iss_idx];
                    r_cmp_p1             <= r_cmp[w_iss_idx];
                    r_busy[w_iss_idx]    <= 1'b0;
                end
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (w_wake1[i]) begin
                        r_rs1_rdy[i] <= 1'b1;
                        r_rs1_val[i] <= rs_if.cdb_val;
                    end
                    if (w_wake2[i]) begin
                        r_rs2_rdy[i] <= 1'b1;
                        r_rs2_val[i] <= rs_if.cdb_val;
                    end
                end
                // The free slot is never busy, so it cannot collide with issue or wake-up.
                if (w_disp) begin
                    r_busy[w_free_idx]    <= 1'b1;
                    r_id[w_free_idx]      <= rs_if.dispatch_ins_id;
                    r_opcode[w_free_idx]  <= rs_if.dispatch_opcode;
                    r_funct3[w_free_idx]  <= rs_if.dispatch_funct3;
                    r_funct7[w_free_idx]  <= rs_if.dispatch_funct7;
                    r_imm[w_free_idx]     <= rs_if.dispatch_imm;
                    r_shamt[w_free_idx]   <= rs_if.dispatch_shamt;
                    r_pc[w_free_idx]      <= rs_if.dispatch_pc;
                    r_cmp[w_free_idx]     <= rs_if.dispatch_is_compressed;
                    r_rs1_rdy[w_free_idx] <= rs_if.dispatch_rs1_rdy || w_d1_hit;
                    r_rs1_val[w_free_idx] <= w_d1_hit ? rs_if.cdb_val : rs_if.dispatch_rs1_val;
                    r_rs1_tag[w_free_idx] <= rs_if.dispatch_rs1_tag;
                    r_rs2_rdy[w_free_idx] <= rs_if.dispatch_rs2_rdy || w_d2_hit;
                    r_rs2_val[w_free_idx] <= w_d2_hit ? rs_if.cdb_val : rs_if.dispatch_rs2_val;
                    r_rs2_tag[w_free_idx] <= rs_if.dispatch_rs2_tag;
                end
            end
        end
    end

    assign rs_if.rs_full           = w_full;
    assign rs_if.have_ins          = r_vld_p1;
    assign rs_if.ins_id            = r_id_p1;
    assign rs_if.rs1_val           = r_rs1_p1;
    assign rs_if.rs2_val           = r_rs2_p1;
    assign rs_if.imm_val           = r_imm_p1;
    assign rs_if.shamt_val         = r_shamt_p1;
    assign rs_if.opcode            = r_opcode_p1;
    assign rs_if.funct3            = r_funct3_p1;
    assign rs_if.funct7            = r_funct7_p1;
    assign rs_if.request_PC        = r_pc_p1;
    assign rs_if.is_compressed_ins = r_cmp_p1;

endmodule
